// File: rtl/soc_clk_enable_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// soc_clk_enable_gen : runtime-reprogrammable, phase-aligned clock-enable strobes
// Rev 1.0
// ============================================================================
module soc_clk_enable_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce_out,
  output logic              locked
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_align  = 2'd1;
  localparam logic [1:0] c_st_settle = 2'd2;
  localparam logic [1:0] c_st_locked = 2'd3;

  localparam logic [DIV_W-1:0] c_one       = DIV_W'(1);
  localparam logic [DIV_W-1:0] c_lock_last = DIV_W'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0] c_def_div   = DIV_W'(DEF_DIV);
  localparam logic [CH_W:0]    c_num_ch    = (CH_W + 1)'(NUM_CH);

  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [DIV_W-1:0]  div_q   [NUM_CH];
  logic [DIV_W-1:0]  div_d   [NUM_CH];
  logic [DIV_W-1:0]  phase_q [NUM_CH];
  logic [DIV_W-1:0]  phase_d [NUM_CH];
  logic [DIV_W-1:0]  cnt_q   [NUM_CH];
  logic [DIV_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] ce_q, ce_d, wrap;
  logic              locked_q, locked_d;
  logic              cfg_err_q, cfg_err_d;
  logic              wr_acc, wr_bad, wr_ok;
  logic              run_q, run_d;

  assign cfg_ready = (state_q != c_st_align);
  assign wr_acc    = cfg_valid & cfg_ready;
  // Phase is only meaningful when the channel actually divides (div >= 2).
  assign wr_bad    = ({1'b0, cfg_chan} >= c_num_ch) |
                     ((cfg_div > c_one) & (cfg_phase >= cfg_div));
  assign wr_ok     = wr_acc & ~wr_bad;
  assign run_q     = (state_q == c_st_settle) | (state_q == c_st_locked);
  assign run_d     = (state_d == c_st_settle) | (state_d == c_st_locked);

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      c_st_idle: begin
        if (en) state_d = c_st_align;
      end
      c_st_align: begin
        state_d    = c_st_settle;
        lock_cnt_d = '0;
      end
      c_st_settle: begin
        if (lock_cnt_q == c_lock_last) state_d = c_st_locked;
        else                           lock_cnt_d = lock_cnt_q + c_one;
        if (wr_ok) state_d = c_st_align;
      end
      c_st_locked: begin
        if (wr_ok) state_d = c_st_align;
      end
      default: state_d = c_st_idle;
    endcase
    if (!en) state_d = c_st_idle;
  end

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    ce_d    = '0;
    wrap    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_ok && (cfg_chan == CH_W'(i))) begin
        div_d[i]   = cfg_div;
        phase_d[i] = cfg_phase;
      end
      wrap[i] = (div_q[i] <= c_one) || (cnt_q[i] == div_q[i] - c_one);
      // Strobes are suppressed on the edge that leaves the running states.
      if (state_q == c_st_align) begin
        cnt_d[i] = phase_q[i];
      end else if (run_q) begin
        cnt_d[i] = wrap[i] ? '0 : cnt_q[i] + c_one;
        ce_d[i]  = wrap[i] & run_d;
      end
    end
  end

  assign locked_d  = (state_d == c_st_locked);
  assign cfg_err_d = wr_acc & wr_bad;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= c_st_idle;
      lock_cnt_q <= '0;
      ce_q       <= '0;
      locked_q   <= 1'b0;
      cfg_err_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= c_def_div;
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      ce_q       <= ce_d;
      locked_q   <= locked_d;
      cfg_err_q  <= cfg_err_d;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= div_d[i];
        phase_q[i] <= phase_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign ce_out  = ce_q;
  assign locked  = locked_q;
  assign cfg_err = cfg_err_q;

endmodule
`default_nettype wire
